// File: rtl/async_fifo_rd_ptr_ctrl_if.sv
// Read-side bus of the asynchronous FIFO pointer controller.
// The consumer side (master) drives the write pointer, read request and flush.
// The controller (slave) returns the address, pointer, flags and pulses.
interface async_fifo_rd_ptr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_ptr_gray;
    logic                  rd_en;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [PW-1:0]         rd_ptr_gray;
    logic                  empty;
    logic [PW-1:0]         level;
    logic                  rd_valid;
    logic                  underflow;

    modport master (
        output wr_ptr_gray,
        output rd_en,
        output flush,
        input  rd_addr,
        input  rd_ptr_gray,
        input  empty,
        input  level,
        input  rd_valid,
        input  underflow
    );

    modport slave (
        input  wr_ptr_gray,
        input  rd_en,
        input  flush,
        output rd_addr,
        output rd_ptr_gray,
        output empty,
        output level,
        output rd_valid,
        output underflow
    );
endinterface

// File: rtl/async_fifo_rd_ptr_ctrl.sv
// Read-domain pointer controller of an asynchronous FIFO.
// Synchronizes the Gray write pointer, advances the binary read pointer on
// accepted reads or jumps it to the write pointer on flush, and produces
// registered empty/level/Gray-pointer outputs plus valid/underflow pulses.
module async_fifo_rd_ptr_ctrl #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    async_fifo_rd_ptr_ctrl_if.slave    bus
);
    localparam int PW = ADDR_WIDTH + 1;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: neighbouring codes differ in exactly one bit.
    function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
        return b ^ {1'b0, b[PW-1:1]};
    endfunction

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    // Synchronizer stages: kept as plain flops with nothing between them.
    logic [PW-1:0] wq1_q;
    logic [PW-1:0] wq2_q;

    // Read-domain state and registered outputs.
    logic [PW-1:0] rd_bin_q;
    logic [PW-1:0] rd_bin_d;
    logic [PW-1:0] rd_gray_q;
    logic [PW-1:0] rd_gray_d;
    logic          empty_q;
    logic          empty_d;
    logic [PW-1:0] level_q;
    logic [PW-1:0] level_d;
    logic          rd_valid_q;
    logic          rd_valid_d;
    logic          underflow_q;
    logic          underflow_d;

    // Decoded synchronized write pointer and the accept qualifier.
    logic [PW-1:0] wr_bin_sync_s;
    logic          accept_s;

    assign wr_bin_sync_s = gray_to_bin(wq2_q);
    assign accept_s      = bus.rd_en & ~empty_q & ~bus.flush;

    // Two-flop synchronizer for the write pointer crossing into this domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wq1_q <= PTR_ZERO;
            wq2_q <= PTR_ZERO;
        end else begin
            wq1_q <= bus.wr_ptr_gray;
            wq2_q <= wq1_q;
        end
    end

    // Next read pointer: flush discards everything up to the synchronized
    // write pointer; otherwise advance by one on an accepted read (wraps naturally).
    always_comb begin
        rd_bin_d = rd_bin_q;
        if (bus.flush) begin
            rd_bin_d = wr_bin_sync_s;
        end else if (accept_s) begin
            rd_bin_d = rd_bin_q + PTR_ONE;
        end else begin
            rd_bin_d = rd_bin_q;
        end
    end

    // Derived next-state values for the registered flags and pulses.
    always_comb begin
        rd_gray_d   = bin_to_gray(rd_bin_d);
        empty_d     = (rd_gray_d == wq2_q);
        level_d     = wr_bin_sync_s - rd_bin_d;
        rd_valid_d  = accept_s;
        underflow_d = bus.rd_en & empty_q & ~bus.flush;
    end

    // Pointer, flag and pulse registers; reset leaves the FIFO empty and idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bin_q    <= PTR_ZERO;
            rd_gray_q   <= PTR_ZERO;
            empty_q     <= 1'b1;
            level_q     <= PTR_ZERO;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            empty_q     <= empty_d;
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.rd_addr     = rd_bin_q[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_gray = rd_gray_q;
    assign bus.empty       = empty_q;
    assign bus.level       = level_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.underflow   = underflow_q;

endmodule
